// File: rtl/multicycle_control_unit.sv
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : Multi-cycle control unit with its own instruction register.
//            Fetches instruction words over a req/ack RAM handshake, decodes
//            them and sequences the datapath control lines through
//            IDLE/FETCH/DECODE/EXEC/MEM/IO/HALT. A bus-wait watchdog turns
//            a stalled handshake into a sticky error and a halt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_unit #(
  parameter int RA_W    = 2,
  parameter int TIMEOUT = 15,
  localparam int IR_W   = 4 + 2 * RA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IR_W-1:0] mem_rdata,
  input  logic            mem_ack,
  input  logic            z,
  input  logic            c,
  input  logic            in_valid,
  input  logic            out_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [1:0]      madd,
  output logic            ir_ld,
  output logic            pc_inc,
  output logic            pc_ld,
  output logic            reg_we,
  output logic [RA_W-1:0] reg_wa,
  output logic [RA_W-1:0] reg_ra,
  output logic [3:0]      alu_s,
  output logic            alu_m,
  output logic [1:0]      shift_sel,
  output logic            cf_en,
  output logic            zf_en,
  output logic            in_en,
  output logic            out_en,
  output logic            halted,
  output logic            err
);

  // State encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_IO     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  // Opcodes
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOVA = 4'h1;
  localparam logic [3:0] OP_MOVB = 4'h2;
  localparam logic [3:0] OP_MOVC = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_RSR  = 4'h8;
  localparam logic [3:0] OP_RSL  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_IN   = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // The wait counter only has to hold values up to TIMEOUT-1: the watchdog
  // fires on the cycle in which the count would reach TIMEOUT.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [2:0]      state;
  logic [2:0]      state_nx;
  logic [IR_W-1:0] ir_q;
  logic [CNT_W-1:0] wait_cnt;
  logic            err_q;

  logic [3:0]      opcode;
  logic            waiting;
  logic            done;
  logic            timeout;

  assign opcode = ir_q[IR_W-1:IR_W-4];

  // Completion condition of whichever handshake the current state waits on
  always_comb begin
    waiting = 1'b0;
    done    = 1'b0;
    case (state)
      S_FETCH: begin
        waiting = 1'b1;
        done    = mem_ack;
      end
      S_MEM: begin
        waiting = 1'b1;
        done    = mem_ack;
      end
      S_IO: begin
        waiting = 1'b1;
        done    = (opcode == OP_IN) ? in_valid : out_ready;
      end
      default: begin
        waiting = 1'b0;
        done    = 1'b0;
      end
    endcase
  end

  // Watchdog trips only on a wait cycle without completion, so a completion
  // landing on the final allowed cycle still wins.
  assign timeout = (TIMEOUT != 0) && waiting && !done && (wait_cnt == CNT_LAST);

  // State register, instruction register, wait counter and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ir_q     <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && mem_ack) begin
        ir_q <= mem_rdata;
      end
      if (state_nx != state) begin
        wait_cnt <= '0;
      end else if (waiting) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  // Next-state logic; branch flags are consulted only while in DECODE
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        if (mem_ack)      state_nx = S_DECODE;
        else if (timeout) state_nx = S_HALT;
      end
      S_DECODE: begin
        case (opcode)
          OP_NOP:                    state_nx = S_FETCH;
          OP_HALT:                   state_nx = S_HALT;
          OP_MOVB, OP_MOVC, OP_JMP:  state_nx = S_MEM;
          OP_JZ:                     state_nx = z ? S_MEM : S_EXEC;
          OP_JC:                     state_nx = c ? S_MEM : S_EXEC;
          OP_IN, OP_OUT:             state_nx = S_IO;
          default:                   state_nx = S_EXEC;
        endcase
      end
      S_EXEC: state_nx = S_FETCH;
      S_MEM, S_IO: begin
        if (done)         state_nx = S_FETCH;
        else if (timeout) state_nx = S_HALT;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath control decode from state and IR; handshake-completion strobes
  // are qualified by the ack/valid/ready seen in the completing cycle
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    madd      = 2'b00;
    ir_ld     = 1'b0;
    pc_inc    = 1'b0;
    pc_ld     = 1'b0;
    reg_we    = 1'b0;
    alu_s     = 4'h0;
    alu_m     = 1'b0;
    shift_sel = 2'b00;
    cf_en     = 1'b0;
    zf_en     = 1'b0;
    in_en     = 1'b0;
    out_en    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        madd    = 2'b00;
        ir_ld   = mem_ack;
        pc_inc  = mem_ack;
      end
      S_EXEC: begin
        alu_s = opcode;
        case (opcode)
          OP_MOVA: begin
            reg_we = 1'b1;
            alu_m  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            reg_we = 1'b1;
            alu_m  = 1'b1;
            cf_en  = 1'b1;
            zf_en  = 1'b1;
          end
          OP_AND, OP_NOT: begin
            reg_we = 1'b1;
            alu_m  = 1'b1;
          end
          OP_RSR: begin
            reg_we    = 1'b1;
            shift_sel = 2'b01;
            cf_en     = 1'b1;
          end
          OP_RSL: begin
            reg_we    = 1'b1;
            shift_sel = 2'b10;
            cf_en     = 1'b1;
          end
          // Only untaken branches reach EXEC: step over the target word
          OP_JZ, OP_JC: pc_inc = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        case (opcode)
          OP_MOVB: begin
            madd   = 2'b10;
            mem_we = 1'b1;
          end
          OP_MOVC: begin
            madd   = 2'b01;
            reg_we = mem_ack;
          end
          default: begin
            madd  = 2'b00;
            pc_ld = mem_ack;
          end
        endcase
      end
      S_IO: begin
        if (opcode == OP_IN) begin
          in_en  = 1'b1;
          reg_we = in_valid;
        end else begin
          out_en = 1'b1;
          alu_m  = 1'b1;
          alu_s  = opcode;
        end
      end
      default: ;
    endcase
  end

  assign reg_wa = ir_q[2*RA_W-1:RA_W];
  assign reg_ra = ir_q[RA_W-1:0];
  assign halted = (state == S_HALT);
  assign err    = err_q;

endmodule

`default_nettype wire
